// File: rtl/if_id_queue.sv
`default_nettype none
//==============================================================================
// Module      : if_id_queue
// Description : Decoupling FIFO between the IF and ID stages with flush.
//               Optional occupancy statistics under IF_ID_QUEUE_STATS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif

module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = `ADDRESS_LEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_pc,
    input  logic [WIDTH-1:0]           in_instruction,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_pc,
    output logic [WIDTH-1:0]           out_instruction,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
`ifdef IF_ID_QUEUE_STATS_EN
    ,
    output logic [15:0]                flush_count,
    output logic [15:0]                stall_count
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_store_pc    [DEPTH];
    logic [WIDTH-1:0]   r_store_instr [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Handshake flags come only from registered occupancy.
    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign count     = r_count;

    assign out_pc          = out_valid ? r_store_pc[r_rd_ptr]    : '0;
    assign out_instruction = out_valid ? r_store_instr[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is left uncleared; emptiness masks stale contents at the outputs.
    always_ff @(posedge clk) begin
        if (w_push && !rst && !flush) begin
            r_store_pc[r_wr_ptr]    <= in_pc;
            r_store_instr[r_wr_ptr] <= in_instruction;
        end
    end

`ifdef IF_ID_QUEUE_STATS_EN
    logic [15:0] r_flush_count;
    logic [15:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (flush && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
            if (in_valid && !in_ready && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign flush_count = r_flush_count;
    assign stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter: DEPTH, 4, queue entries; power of two, 2..16.
REQ-002 Parameter: WIDTH, `ADDRESS_LEN (32), width of the pc and instruction fields.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: flush  input  1  branch taken; discard all queued entries.
REQ-006 Port: in_valid  input  1  the IF stage presents an entry.
REQ-007 Port: in_pc  input  WIDTH  next_pc from the IF stage.
REQ-008 Port: in_instruction  input  WIDTH  instruction_out from the IF stage.
REQ-009 Port: in_ready  output  1  queue can accept an entry; the IF stage freezes when this is low.
REQ-010 Port: out_valid  output  1  head entry is valid.
REQ-011 Port: out_pc  output  WIDTH  pc of the head entry.
REQ-012 Port: out_instruction  output  WIDTH  instruction of the head entry.
REQ-013 Port: out_ready  input  1  the ID stage consumes the head entry (low on hazard or freeze).
REQ-014 Port: count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Push: in_valid && in_ready at the edge; write {in_pc, in_instruction} at wr_ptr; wr_ptr+1 mod DEPTH.
REQ-016 Pop: out_valid && out_ready at the edge; rd_ptr+1 mod DEPTH.
REQ-017 in_ready = (count != DEPTH); depends only on registered state, with no combinational path from out_ready or in_valid.
REQ-018 out_valid = (count != 0); out_pc/out_instruction = storage[rd_ptr], driven combinationally from registers; 0 when count == 0.
REQ-019 Latency: an entry pushed at edge N is visible on the outputs after edge N; there is no same-cycle bypass when empty.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH: count unchanged; both pointers advance.
REQ-021 Full (count == DEPTH): push blocked even when a pop occurs in the same cycle; count becomes DEPTH-1.
REQ-022 Empty: a pop attempt is ignored because out_valid is 0; a push sets count to 1.
REQ-023 Pointers wrap from DEPTH-1 to 0 with no data loss; FIFO order is preserved across the wrap.
REQ-024 Flush: at the edge, count, wr_ptr and rd_ptr go to 0; the push and pop in that cycle are discarded.
REQ-025 Flush priority: rst > flush > push/pop.
REQ-026 Storage contents are not cleared by flush; only the pointers and count are reset.

Reset
REQ-027 With rst high at an edge, the following are set to 0: count, wr_ptr, rd_ptr, out_valid, out_pc and out_instruction; in_ready is set to 1.
REQ-028 Reset asserted mid-operation discards all entries at that edge; the queue is usable in the cycle after rst deasserts.
REQ-029 Storage array reset is optional; outputs are masked to 0 while empty.

Configuration
REQ-030 Macro IF_ID_QUEUE_STATS_EN; with it defined, two outputs are added: flush_count (16 bits) and stall_count (16 bits).
REQ-031 flush_count increments once per cycle with flush high; stall_count increments once per cycle with in_valid && !in_ready; both saturate at 16'hFFFF and clear only on rst.
REQ-032 Without IF_ID_QUEUE_STATS_EN, these ports and counters are absent and the remaining behaviour is identical.

Verification
REQ-033 Reset, then push pc 0,4,8,12 on 4 consecutive cycles with out_ready=0 -> count=4, in_ready=0, out_pc=0.
REQ-034 From full, set out_ready=1 with in_valid=1 for one cycle -> count=3, in_ready=1, out_pc=4, and the blocked entry is not stored.
REQ-035 Stream 10 entries (pc 0..36) with in_valid=1 and out_ready=1 -> ID receives pc 0..36 in order across the pointer wrap, and count stays at most 1.
REQ-036 With count=3, assert flush together with push and pop -> next cycle count=0, out_valid=0, in_ready=1; a subsequent push of pc 0x100 appears as out_pc=0x100.
REQ-037 With count=2, assert rst together with in_valid -> next cycle count=0 and all outputs 0.
REQ-038 With STATS_EN, hold full with in_valid=1 for 5 cycles, then flush twice -> stall_count=5, flush_count=2.
